if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 204 ++++++++++++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch front end. Issues single-word reads to a
// synchronous instruction memory, buffers returned words with their PC in a
// 2-entry FIFO, and presents the FIFO head to decode on a valid/ready handshake.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   redirect,       branch/jump request; target PC (low two bits dropped)
//   redirect_pc
//   imem_en,        read request and byte address (PC[7:0]) to imem
//   imem_addr
//   imem_data       read data, valid the cycle after imem_en
//   id_valid,       decode handshake; transfer when both high at an edge
//   id_ready
//   id_inst, id_pc  instruction word and its PC at the FIFO head
//   fetch_cnt       accepted-instruction counter, only with IF_FETCH_CNT_EN
//
// Optional feature macro: IF_FETCH_CNT_EN (adds fetch_cnt port and counter).

// Small generic FIFO with synchronous flush; DEPTH must be a power of two.
// Latency: a pushed word is visible at head_dat one cycle after the push edge.
// Backpressure: none internal; the caller must never push when full.
module fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Storage is left as is; only the occupancy bookkeeping is cleared.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Fetch stage: PC sequencer, one outstanding imem read, 2-entry output buffer.
// Latency: imem_en to id_valid is 2 cycles; one instruction per cycle when fed.
// Backpressure: id_ready low stalls issue once buffered + in-flight words reach 2.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_ent_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;

    logic        pop;
    logic        room;
    logic        push_vld;
    logic [1:0]  fifo_cnt;
    fetch_ent_t  push_dat;
    fetch_ent_t  head_dat;

    assign pop = id_valid && id_ready;

    // Issue only if everything already committed (buffered plus in flight),
    // minus what decode takes this cycle, still leaves a free FIFO slot when
    // the new response lands. This is what keeps pushes off a full FIFO.
    assign room = (({1'b0, fifo_cnt} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;

    always_comb begin
        state_d = state_q;
        imem_en = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                imem_en = !redirect && room;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q          <= RESET_PC & ~32'd3;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            // imem_en is already low during a redirect, so inflight clears.
            inflight_q <= imem_en;
            if (imem_en) begin
                inflight_pc_q <= pc_q;
            end
            if (redirect) begin
                pc_q <= redirect_pc & ~32'd3;
            end else if (imem_en) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    assign imem_addr = pc_q[7:0];

    // A response returning in a redirect cycle belongs to the old path.
    assign push_vld      = inflight_q && !redirect;
    assign push_dat.inst = imem_data;
    assign push_dat.pc   = inflight_pc_q;

    fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (2)
    ) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (redirect),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop && !redirect),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign id_valid = (fifo_cnt != 2'd0);
    assign id_inst  = head_dat.inst;
    assign id_pc    = head_dat.pc;

`ifdef IF_FETCH_CNT_EN
    // Counts decode acceptances, including one that coincides with a redirect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt <= '0;
        end else if (pop) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model of the fetch stream compared every
// cycle, plus directed scenarios with literal expectations.
module tb_if_stage;
    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    if_stage #(.RESET_PC(RESET_PC_TB)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory content: a word derived only from the byte address.
    function automatic logic [31:0] inst_of(input logic [7:0] a);
        return {a ^ 8'h5A, ~a, 8'hC3, a};
    endfunction

    // Memory responder state, captured from the request of the previous cycle.
    bit         mem_req = 0;
    logic [7:0] mem_addr = '0;

    // Reference model: next PC to fetch, words awaiting decode (by PC),
    // the single in-flight request, and the accepted count.
    bit          m_run = 0;
    logic [31:0] m_pc = RESET_PC_TB & ~32'd3;
    logic [31:0] m_q[$];
    bit          m_infl = 0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_cnt = '0;

    always begin : cmp
        bit exp_valid;
        bit pop;
        bit exp_en;
        @(negedge CLK);
        #2;
        if (RST) begin
            m_run = 0;
            m_pc = RESET_PC_TB & ~32'd3;
            m_q.delete();
            m_infl = 0;
            m_cnt = '0;
            mem_req = 0;
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_imem_en", 32'(imem_en), 32'd0);
            chk("rst_id_inst", id_inst, 32'd0);
            chk("rst_id_pc", id_pc, 32'd0);
            chk("rst_imem_addr", 32'(imem_addr), 32'(m_pc[7:0]));
`ifdef IF_FETCH_CNT_EN
            chk("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif
        end else begin
            exp_valid = (m_q.size() != 0);
            pop = exp_valid && id_ready;
            exp_en = m_run && !redirect &&
                     ((m_q.size() + int'(m_infl) - int'(pop)) < 2);
            chk("cmp_id_valid", 32'(id_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("cmp_id_pc", id_pc, m_q[0]);
                chk("cmp_id_inst", id_inst, inst_of(m_q[0][7:0]));
            end
            chk("cmp_imem_en", 32'(imem_en), 32'(exp_en));
            chk("cmp_imem_addr", 32'(imem_addr), 32'(m_pc[7:0]));
`ifdef IF_FETCH_CNT_EN
            chk("cmp_fetch_cnt", fetch_cnt, m_cnt);
`endif
            mem_req = imem_en;
            mem_addr = imem_addr;
            // Effect of the coming clock edge.
            if (redirect) begin
                m_pc = redirect_pc & ~32'd3;
                m_q.delete();
                m_infl = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_infl_pc);
                m_infl = exp_en;
                if (exp_en) begin
                    m_infl_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
            if (pop) m_cnt = m_cnt + 32'd1;
            m_run = 1;
        end
    end

    // One cycle of stimulus: inputs change on the falling edge; callers look
    // at DUT outputs on return (3 time units after the falling edge).
    task automatic cyc(input bit rst, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(negedge CLK);
        RST = rst;
        id_ready = rdy;
        redirect = rd;
        redirect_pc = rpc;
        imem_data = mem_req ? inst_of(mem_addr) : $urandom;
        #3;
    endtask

    logic [31:0] got[$];
    logic [7:0]  iss[$];
    int first;
    int en_cnt;
    int n;

    initial begin
        // Reset state.
        repeat (3) cyc(1, 0, 0, 0);
        chk("reset_valid", 32'(id_valid), 32'd0);
        chk("reset_en", 32'(imem_en), 32'd0);
        chk("reset_pc", id_pc, 32'd0);
        chk("reset_inst", id_inst, 32'd0);

        // Streaming from RESET_PC with decode always ready.
        first = -1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            if (id_valid && first < 0) first = i;
            if (id_valid) got.push_back(id_pc);
        end
        chk("first_valid_cycle", 32'(first), 32'd3);
        chk("stream_len", 32'(got.size()), 32'd5);
        for (int k = 0; k < got.size(); k++) chk("stream_pc", got[k], 32'(4 * k));

        // Decode stalled for 10 cycles, then released.
        cyc(1, 0, 0, 0);
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            en_cnt += int'(imem_en);
            if (i >= 3) chk("stall_pc", id_pc, 32'd0);
        end
        chk("stall_en_pulses", 32'(en_cnt), 32'd2);
        got.delete();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            got.push_back(id_valid ? id_pc : 32'hDEAD_BEEF);
        end
        for (int k = 0; k < 3; k++) chk("release_pc", got[k], 32'(4 * k));

        // Redirect while the buffer is full.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("full_valid", 32'(id_valid), 32'd1);
        cyc(0, 0, 1, 32'h0000_0043);
        chk("redir_cycle_en", 32'(imem_en), 32'd0);
        cyc(0, 1, 0, 0);
        chk("redir_next_valid", 32'(id_valid), 32'd0);
        chk("redir_next_en", 32'(imem_en), 32'd1);
        chk("redir_next_addr", 32'(imem_addr), 32'h40);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("redir_first_valid", 32'(id_valid), 32'd1);
        chk("redir_first_pc", id_pc, 32'h40);

        // Address wrap at the top of the 256-byte window.
        cyc(0, 1, 1, 32'h0000_00F0);
        got.delete();
        iss.delete();
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0);
            if (imem_en) iss.push_back(imem_addr);
            if (id_valid) got.push_back(id_pc);
        end
        chk("wrap_lens", 32'(got.size() >= 5 && iss.size() >= 5), 32'd1);
        if (got.size() >= 5 && iss.size() >= 5) begin
            chk("wrap_iss_fc", 32'(iss[3]), 32'hFC);
            chk("wrap_iss_00", 32'(iss[4]), 32'h00);
            chk("wrap_pc_fc", got[3], 32'hFC);
            chk("wrap_pc_100", got[4], 32'h100);
        end

        // Reset mid-stream with the buffer full, then refetch.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("midrst_full", 32'(id_valid), 32'd1);
        cyc(1, 0, 0, 0);
        chk("midrst_valid", 32'(id_valid), 32'd0);
        chk("midrst_en", 32'(imem_en), 32'd0);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            if (id_valid) got.push_back(id_pc);
        end
        chk("refetch_any", 32'(got.size() != 0), 32'd1);
        if (got.size() != 0) chk("refetch_pc", got[0], RESET_PC_TB);

        // Redirect in IDLE only moves the PC.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_0081);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            if (id_valid) got.push_back(id_pc);
        end
        chk("idle_redir_any", 32'(got.size() != 0), 32'd1);
        if (got.size() != 0) chk("idle_redir_pc", got[0], 32'h80);

        // Five transfers, then one that coincides with a redirect.
        cyc(1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            cyc(0, 1, 0, 0);
            if (id_valid && id_ready) n++;
        end
        chk("five_pops", 32'(n), 32'd5);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10 && !id_valid; i++) cyc(0, 0, 0, 0);
        chk("pre_redir_valid", 32'(id_valid), 32'd1);
        cyc(0, 1, 1, 32'h0000_0040);
        chk("redir_pop", 32'(id_valid && id_ready), 32'd1);
        cyc(0, 0, 0, 0);
`ifdef IF_FETCH_CNT_EN
        chk("fetch_cnt_6", fetch_cnt, 32'd6);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit rd;
            logic [31:0] rpc;
            r = ($urandom % 200) == 0;
            rd = ($urandom % 16) == 0;
            rpc = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 : 32'($urandom);
            cyc(r, ($urandom % 4) != 0, rd, rpc);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
